trng_fetch_buffer: RTL and testbench

- Initiator side of the TRNG `trng_request`/`ready` handshake.
- Repeatedly requests 32-bit words from the TRNG unit and applies a repetition-count health test to each one.
- Buffers passing words in a small FIFO.
- Serves them to downstream crypto cores (key/nonce generation) over a valid/ready stream.

---
 rtl/trng_fetch_buffer_pkg.sv | 14 +
 rtl/trng_fetch_buffer_fifo.sv | 58 +++++
 rtl/trng_fetch_buffer.sv | 139 +++++++++++++
 tb/tb_trng_fetch_buffer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trng_fetch_buffer_pkg.sv
// Shared crypto package: TRNG word width, fetch FSM states and the default
// repetition-count health limit used by the key-material buffers.
package trng_fetch_buffer_pkg;

    localparam int TRNG_WORD_W = 32;
    localparam int DEFAULT_REP_LIMIT = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/trng_fetch_buffer_fifo.sv
// rng_word_fifo: small power-of-two word FIFO with a combinational head,
// shared by the key-material buffers.
module rng_word_fifo
    import trng_fetch_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [TRNG_WORD_W-1:0]   i_data,
    input  logic                     i_pop,
    output logic [TRNG_WORD_W-1:0]   o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = $clog2(DEPTH);

    logic [TRNG_WORD_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]          r_wr;
    logic [PW-1:0]          r_rd;
    logic [PW:0]            r_count;

    // Storage is cleared so the head reads zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr <= '0;
        end else if (i_push) begin
            r_mem[r_wr] <= i_data;
            r_wr        <= r_wr + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd <= '0;
        end else if (i_pop) begin
            r_rd <= r_rd + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_push && !i_pop) begin
            r_count <= r_count + (PW+1)'(1);
        end else if (!i_push && i_pop) begin
            r_count <= r_count - (PW+1)'(1);
        end
    end

    assign o_head  = r_mem[r_rd];
    assign o_count = r_count;

endmodule

// File: rtl/trng_fetch_buffer.sv
// trng_fetch_buffer: requests TRNG words, applies a repetition-count health
// test and serves passing words to crypto cores over a valid/ready stream.
module trng_fetch_buffer
    import trng_fetch_buffer_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int REP_LIMIT = DEFAULT_REP_LIMIT,
    parameter int TIMEOUT   = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_enable,
    output logic                     o_trng_request,
    input  logic                     i_trng_ready,
    input  logic [TRNG_WORD_W-1:0]   i_trng_data,
    output logic [TRNG_WORD_W-1:0]   o_rnd_data,
    output logic                     o_rnd_valid,
    input  logic                     i_rnd_ready,
    output logic [$clog2(DEPTH):0]   o_fifo_count,
    output logic                     o_health_fail,
    input  logic                     i_health_clear,
    output logic                     o_timeout_err
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam int RW = $clog2(REP_LIMIT) + 1;

    fetch_state_e r_state;
    fetch_state_e w_next;

    logic                   r_req;
    logic [TW-1:0]          r_timer;
    logic                   r_timeout;
    logic                   r_health_fail;
    logic [TRNG_WORD_W-1:0] r_prev_word;
    logic                   r_prev_valid;
    logic [RW-1:0]          r_rep_cnt;

    logic [CW-1:0]          w_count;
    logic [TRNG_WORD_W-1:0] w_head;
    logic                   w_valid;
    logic                   w_pop;
    logic                   w_in_req;
    logic                   w_capture;
    logic                   w_expire;
    logic                   w_repeat;
    logic                   w_push;
    logic                   w_room;
    logic                   w_start;
    logic [RW-1:0]          w_rep_inc;

    assign w_valid   = (w_count != '0);
    assign w_pop     = w_valid & i_rnd_ready;
    assign w_in_req  = (r_state == REQ);
    assign w_capture = w_in_req & i_trng_ready;
    assign w_expire  = w_in_req & ~i_trng_ready
                     & (r_timer == TW'(TIMEOUT - 1));
    assign w_repeat  = r_prev_valid & (i_trng_data == r_prev_word);
    // A clear coinciding with a capture lets the word through.
    assign w_push    = w_capture & (~w_repeat | i_health_clear);
    assign w_room    = (w_count - CW'(w_pop)) < CW'(DEPTH);
    assign w_start   = i_enable & ~r_health_fail & ~r_timeout
                     & w_room & ~i_trng_ready;
    assign w_rep_inc = r_rep_cnt + RW'(1);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_start) w_next = REQ;
            REQ:     if (w_capture || w_expire) w_next = RELEASE;
            RELEASE: if (!i_trng_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_req   <= (w_next == REQ);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer   <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timer   <= w_in_req ? r_timer + TW'(1) : '0;
            r_timeout <= r_timeout | w_expire;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_health_fail <= 1'b0;
            r_rep_cnt     <= '0;
            r_prev_word   <= '0;
            r_prev_valid  <= 1'b0;
        end else if (i_health_clear) begin
            r_health_fail <= 1'b0;
            r_rep_cnt     <= '0;
            r_prev_valid  <= 1'b0;
            if (w_capture) r_prev_word <= i_trng_data;
        end else if (w_capture) begin
            if (w_repeat) begin
                if (r_rep_cnt < RW'(REP_LIMIT - 1)) r_rep_cnt <= w_rep_inc;
                if (w_rep_inc >= RW'(REP_LIMIT - 1)) r_health_fail <= 1'b1;
            end else begin
                r_prev_word  <= i_trng_data;
                r_prev_valid <= 1'b1;
                r_rep_cnt    <= '0;
            end
        end
    end

    rng_word_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (i_trng_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign o_trng_request = r_req;
    assign o_rnd_data     = w_head;
    assign o_rnd_valid    = w_valid;
    assign o_fifo_count   = w_count;
    assign o_health_fail  = r_health_fail;
    assign o_timeout_err  = r_timeout;

endmodule

// File: tb/tb_trng_fetch_buffer.sv
// Bench for trng_fetch_buffer: directed phases plus a randomized run, all
// checked every cycle against a queue-based model of the fetch buffer.
module tb_trng_fetch_buffer;

    localparam int DEPTH = 4;
    localparam int REP_LIMIT = 3;
    localparam int TIMEOUT = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        trng_ready = 1'b0;
    logic [31:0] trng_data = '0;
    logic        rnd_ready = 1'b0;
    logic        health_clear = 1'b0;
    logic        o_trng_request;
    logic [31:0] o_rnd_data;
    logic        o_rnd_valid;
    logic [2:0]  o_fifo_count;
    logic        o_health_fail;
    logic        o_timeout_err;

    trng_fetch_buffer #(
        .DEPTH(DEPTH), .REP_LIMIT(REP_LIMIT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_enable       (enable),
        .o_trng_request (o_trng_request),
        .i_trng_ready   (trng_ready),
        .i_trng_data    (trng_data),
        .o_rnd_data     (o_rnd_data),
        .o_rnd_valid    (o_rnd_valid),
        .i_rnd_ready    (rnd_ready),
        .o_fifo_count   (o_fifo_count),
        .o_health_fail  (o_health_fail),
        .i_health_clear (health_clear),
        .o_timeout_err  (o_timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp,
                     $time);
        end
    endtask

    // TRNG responder: answers after lat request cycles, may hold ready a
    // few cycles after request drops.
    logic [31:0] wq[$];
    logic [31:0] last_w = '0;
    int lat = 4, rc = 0, hold = 0, hold_max = 0;
    int serve_left = 1000000, served = 0;
    bit rand_mode = 0, consumed = 0;

    function automatic logic [31:0] gen_word();
        if (rand_mode && $urandom_range(0, 2) == 0) return last_w;
        last_w = $urandom;
        return last_w;
    endfunction

    initial forever begin
        @(posedge clk); #1;
        if (rst) begin
            trng_ready = 0; rc = 0; consumed = 0; hold = 0;
        end else if (o_trng_request) begin
            rc++;
            if (rand_mode && rc == 1) lat = $urandom_range(1, 6);
            if (!trng_ready && serve_left > 0 && rc >= lat) begin
                if (wq.size() == 0) wq.push_back(gen_word());
                trng_data = wq[0];
                trng_ready = 1;
            end
        end else begin
            rc = 0;
            if (trng_ready) begin
                if (!consumed) begin
                    void'(wq.pop_front());
                    served++; serve_left--; consumed = 1;
                    hold = $urandom_range(0, hold_max);
                end
                if (hold == 0) begin
                    trng_ready = 0; consumed = 0;
                end else begin
                    hold--;
                end
            end
        end
    end

    // Behavioural model: FIFO as a queue, handshake and health rules
    // evaluated once per cycle from the inputs.
    logic [31:0] mq[$];
    logic [31:0] popq[$];
    logic [31:0] m_prev;
    bit m_pv, m_hf, m_to, m_req, m_rel;
    int m_rep, m_run, coincide = 0;

    initial forever begin
        bit pop, cap, expire, allowed, nreq, pushed;
        @(negedge clk);
        if (rst) begin
            mq.delete(); m_prev = '0; m_pv = 0; m_hf = 0; m_to = 0;
            m_req = 0; m_rel = 0; m_rep = 0; m_run = 0;
        end
        chk("cyc_request", o_trng_request, m_req);
        chk("cyc_valid", o_rnd_valid, mq.size() != 0);
        chk("cyc_count", o_fifo_count, mq.size());
        chk("cyc_health", o_health_fail, m_hf);
        chk("cyc_timeout", o_timeout_err, m_to);
        if (mq.size() != 0) chk("cyc_data", o_rnd_data, mq[0]);
        if (rst) begin
            chk("cyc_reset_data", o_rnd_data, 0);
            continue;
        end
        if (o_rnd_valid && rnd_ready) popq.push_back(o_rnd_data);
        pop = (mq.size() != 0) && rnd_ready;
        cap = m_req && trng_ready;
        expire = 0;
        pushed = 0;
        allowed = enable && !m_hf && !m_to && !trng_ready
                  && (mq.size() - int'(pop) < DEPTH);
        if (m_req) begin
            if (!cap) begin
                m_run++;
                if (m_run == TIMEOUT) expire = 1;
            end
            nreq = !(cap || expire);
        end else begin
            m_run = 0;
            nreq = !m_rel && allowed;
        end
        if (cap || expire) m_rel = 1;
        else if (m_rel && !trng_ready) m_rel = 0;
        if (expire) m_to = 1;
        if (pop) void'(mq.pop_front());
        if (health_clear) begin
            if (cap) begin mq.push_back(trng_data); pushed = 1; end
            m_hf = 0; m_rep = 0; m_pv = 0;
        end else if (cap) begin
            if (m_pv && trng_data == m_prev) begin
                m_rep++;
                if (m_rep >= REP_LIMIT - 1) m_hf = 1;
            end else begin
                mq.push_back(trng_data); pushed = 1;
                m_prev = trng_data; m_pv = 1; m_rep = 0;
            end
        end
        if (pop && pushed) coincide++;
        m_req = nreq;
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic do_reset();
        tick();
        rst = 1; enable = 0; rnd_ready = 0; health_clear = 0;
        served = 0;
        repeat (2) tick();
        rst = 0;
    endtask

    task automatic wait_cnt(input int n, input int lim, input string nm);
        int i = 0;
        while (o_fifo_count != n && i < lim) begin
            @(negedge clk); i++;
        end
        chk(nm, o_fifo_count, n);
    endtask

    function automatic logic sig(input int w);
        case (w)
            0: return o_trng_request;
            1: return o_health_fail;
            default: return o_timeout_err;
        endcase
    endfunction

    task automatic wait_sig(input int w, input int lim, input string nm);
        int i = 0;
        while (!sig(w) && i < lim) begin
            @(negedge clk); i++;
        end
        chk(nm, sig(w), 1);
    endtask

    task automatic pop_n(input int n);
        popq.delete();
        tick(); rnd_ready = 1;
        repeat (n) tick();
        rnd_ready = 0;
        chk("pop_count", popq.size(), n);
    endtask

    initial begin
        logic [31:0] exp_w;
        int t0, base;

        @(negedge clk);
        chk("rst_request", o_trng_request, 0);
        chk("rst_valid", o_rnd_valid, 0);
        chk("rst_count", o_fifo_count, 0);
        chk("rst_data", o_rnd_data, 0);
        chk("rst_flags", {o_health_fail, o_timeout_err}, 0);

        // Fill and drain with a slow TRNG
        wq = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
               32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
        lat = 32;
        tick(); rst = 0; enable = 1;
        wait_cnt(4, 400, "fill_count");
        repeat (40) @(negedge clk);
        chk("fill_handshakes", served, 4);
        chk("fill_count_hold", o_fifo_count, 4);
        chk("fill_req_idle", o_trng_request, 0);
        pop_n(4);
        for (int i = 0; i < 4 && i < popq.size(); i++)
            chk("drain_order", popq[i], 32'h11111111 * (i + 1));
        wait_sig(0, 10, "drain_req_resume");

        // Repetition test
        wq = '{32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF,
               32'h12345678};
        lat = 3; serve_left = 5;
        do_reset(); enable = 1;
        wait_sig(1, 200, "rep_health_fail");
        chk("rep_served", served, 3);
        chk("rep_count", o_fifo_count, 1);
        chk("rep_head", o_rnd_data, 32'hDEADBEEF);
        repeat (20) @(negedge clk);
        chk("rep_no_req", o_trng_request, 0);
        chk("rep_served_hold", served, 3);
        tick(); health_clear = 1;
        tick(); health_clear = 0;
        wait_cnt(3, 100, "clear_count");
        chk("clear_health", o_health_fail, 0);
        pop_n(3);
        if (popq.size() == 3) begin
            chk("clear_pop0", popq[0], 32'hDEADBEEF);
            chk("clear_pop1", popq[1], 32'hDEADBEEF);
            chk("clear_pop2", popq[2], 32'h12345678);
        end

        // Timeout: two words served, then the TRNG goes silent
        wq.delete(); lat = 2; serve_left = 2;
        do_reset(); enable = 1;
        wait_cnt(2, 100, "to_prefill");
        wait_sig(0, 20, "to_req_rise");
        t0 = cyc;
        wait_sig(2, 400, "to_err_rise");
        chk("to_latency", cyc - t0, 256);
        chk("to_req_drop", o_trng_request, 0);
        repeat (30) @(negedge clk);
        chk("to_no_req", o_trng_request, 0);
        tick(); rnd_ready = 1;
        repeat (3) tick();
        chk("to_drain", o_fifo_count, 0);
        chk("to_sticky", o_timeout_err, 1);
        rnd_ready = 0;

        // Reset in the middle of a request
        wq = '{32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3, 32'hB0B0B0B0};
        lat = 32; serve_left = 1000;
        do_reset(); enable = 1;
        wait_cnt(3, 400, "mid_prefill");
        wait_sig(0, 20, "mid_req");
        tick(); rst = 1; #1;
        chk("mid_rst_request", o_trng_request, 0);
        chk("mid_rst_valid", o_rnd_valid, 0);
        chk("mid_rst_count", o_fifo_count, 0);
        chk("mid_rst_flags", {o_health_fail, o_timeout_err}, 0);
        exp_w = wq.size() != 0 ? wq[0] : 32'hB0B0B0B0;
        chk("mid_next_word", exp_w, 32'hB0B0B0B0);
        lat = 2;
        tick(); rst = 0;
        wait_cnt(1, 50, "mid_first_push");
        chk("mid_first_word", o_rnd_data, 32'hB0B0B0B0);

        // Randomized traffic
        wq.delete(); rand_mode = 1; hold_max = 2; serve_left = 1000000;
        do_reset();
        base = served;
        coincide = 0;
        repeat (4000) begin
            tick();
            enable = ($urandom_range(0, 9) != 0);
            rnd_ready = $urandom_range(0, 1);
            health_clear = ($urandom_range(0, 49) == 0);
        end
        health_clear = 0;
        chk("rand_push_pop_overlap", coincide > 0, 1);
        chk("rand_traffic", (served - base) >= 100, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
